// File: rtl/sci_buf_pkg.sv
// Shared definitions for the SCI frame buffer: drain FSM states and default sizing.
package sci_buf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FIN   = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 512;

endpackage

// File: rtl/sci_skid2.sv
// Two-entry skid buffer with valid/ready on both sides; head entry drives the output.
module sci_skid2
   import sci_buf_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push_valid,
   input  logic [WIDTH-1:0] i_push_data,
   output logic             o_push_ready,
   output logic             o_pop_valid,
   input  logic             i_pop_ready,
   output logic [WIDTH-1:0] o_pop_data,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign o_push_ready = (r_count != 2'd2);
   assign o_pop_valid  = (r_count != 2'd0);
   assign o_pop_data   = r_head;
   assign o_count      = r_count;
   assign w_push       = i_push_valid && o_push_ready;
   assign w_pop        = o_pop_valid && i_pop_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_push_data;
               else                 r_tail <= i_push_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // Simultaneous push/pop keeps occupancy; the new word lands behind what remains.
               if (r_count == 2'd1) begin
                  r_head <= i_push_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sci_frame_buf.sv
// Frame buffer: fills an external RAM word by word, then drains the stored frame
// in address order through a two-entry skid buffer that absorbs RAM read latency.
module sci_frame_buf
   import sci_buf_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int A     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [A:0]       level,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [A-1:0]     ram_addr,
   output logic             ram_w_r,
   output logic [WIDTH-1:0] ram_din,
   input  logic [WIDTH-1:0] ram_dout
);

   localparam logic [A:0] LVL_FULL = (A+1)'(DEPTH);
   localparam logic [A:0] LVL_ONE  = (A+1)'(1);

   state_t     r_state;
   state_t     w_state_next;
   logic [A:0] r_level;
   logic [A:0] r_issued;
   logic [A:0] r_sent;
   logic       r_inflight;
   logic       w_fill;
   logic       w_pop;
   logic       w_remain;
   logic       w_issue;
   logic       w_last;
   logic       w_enter_fin;
   logic       w_skid_ready;
   logic [1:0] w_skid_count;
   logic [2:0] w_occ;

   assign in_ready = (r_state == ST_IDLE) && (r_level < LVL_FULL) && !start;
   assign w_fill   = in_valid && in_ready;
   assign w_pop    = out_valid && out_ready;
   assign w_remain = (r_issued < r_level);

   // Occupancy after this cycle's pop, so a steady stream can issue one read per cycle.
   assign w_occ    = {1'b0, w_skid_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue  = (r_state == ST_DRAIN) && w_remain && (w_occ < 3'd2);
   assign w_last   = w_pop && (r_sent == r_level - LVL_ONE);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_next = (r_level != '0) ? ST_DRAIN : ST_FIN;
         ST_DRAIN: if (w_last) w_state_next = ST_FIN;
         ST_FIN:   w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   assign w_enter_fin = (w_state_next == ST_FIN) && (r_state != ST_FIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_level    <= '0;
         r_issued   <= '0;
         r_sent     <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_enter_fin)  r_level <= '0;
         else if (w_fill)  r_level <= r_level + LVL_ONE;
         if (r_state == ST_FIN) begin
            r_issued <= '0;
            r_sent   <= '0;
         end else begin
            if (w_issue) r_issued <= r_issued + LVL_ONE;
            if (w_pop)   r_sent   <= r_sent + LVL_ONE;
         end
         r_inflight <= w_issue || (r_inflight && !w_skid_ready);
      end
   end

   assign busy     = (r_state == ST_DRAIN);
   assign done     = (r_state == ST_FIN);
   assign level    = r_level;
   assign ram_w_r  = w_fill;
   assign ram_addr = w_fill ? r_level[A-1:0] : r_issued[A-1:0];
   assign ram_din  = w_fill ? in_data : '0;

   sci_skid2 #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_push_valid (r_inflight),
      .i_push_data  (ram_dout),
      .o_push_ready (w_skid_ready),
      .o_pop_valid  (out_valid),
      .i_pop_ready  (out_ready),
      .o_pop_data   (out_data),
      .o_count      (w_skid_count)
   );

endmodule

// File: tb/tb_sci_frame_buf.sv
// Self-checking bench for sci_frame_buf: directed and randomized fill/drain frames
// compared against a queue model of the stored frame.
module tb_sci_frame_buf;

   localparam int WIDTH = 8;
   localparam int DEPTH = 512;
   localparam int A     = 9;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             start = 1'b0;
   logic             busy;
   logic             done;
   logic [A:0]       level;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [A-1:0]     ram_addr;
   logic             ram_w_r;
   logic [WIDTH-1:0] ram_din;
   logic [WIDTH-1:0] ram_dout = '0;

   logic [WIDTH-1:0] mem [0:DEPTH-1];
   logic [WIDTH-1:0] q [$];
   int n_cmp = 0;
   int n_mis = 0;

   sci_frame_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .level     (level),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .ram_addr  (ram_addr),
      .ram_w_r   (ram_w_r),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   always #5 clk = ~clk;

   // External synchronous RAM: read data appears one clock after the address.
   always @(posedge clk) begin
      if (ram_w_r) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_word(input logic [WIDTH-1:0] d);
      logic exp_rdy;
      exp_rdy = (q.size() < DEPTH);
      chk("level_pre_fill", 32'(level), 32'(q.size()));
      in_valid = 1'b1;
      in_data  = d;
      #1;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("ram_w_r_fill", 32'(ram_w_r), 32'(exp_rdy));
      if (exp_rdy) begin
         chk("ram_addr_fill", 32'(ram_addr), 32'(q.size()));
         chk("ram_din_fill", 32'(ram_din), 32'(d));
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (exp_rdy) q.push_back(d);
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      #1;
      chk("ram_w_r_idle", 32'(ram_w_r), 32'd0);
      tick();
   endtask

   // mode 0: out_ready high, 1: fixed 1,0,0,1,0,1 pattern, 2: random. abort>=0 stops after that many words.
   task automatic drain(input int mode, input int abort, input bit with_valid);
      bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int n, cyc, got, last;
      bit seen_done, prev_stall, aborted;
      logic [WIDTH-1:0] prev_d;
      n = q.size();
      cyc = 0; got = 0; last = -10;
      seen_done = 1'b0; prev_stall = 1'b0; aborted = 1'b0; prev_d = '0;
      start = 1'b1;
      if (with_valid) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
      end
      #1;
      chk("in_ready_at_start", 32'(in_ready), 32'd0);
      chk("ram_w_r_at_start", 32'(ram_w_r), 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      in_valid = 1'b0;
      while (!seen_done && !aborted && cyc < 3000) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pat[cyc % 6];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (cyc == 0) begin
            chk("busy_first", 32'(busy), 32'(n > 0));
            if (n > 0) begin
               chk("first_read_addr", 32'(ram_addr), 32'd0);
               chk("first_read_w_r", 32'(ram_w_r), 32'd0);
            end
         end
         if (cyc < 2) chk("early_valid", 32'(out_valid), 32'd0);
         if (cyc == 2 && n > 0) chk("first_valid", 32'(out_valid), 32'd1);
         if (mode == 0 && n > 0 && cyc >= 2 && got < n) chk("no_gap", 32'(out_valid), 32'd1);
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(prev_d));
         end
         if (done) begin
            seen_done = 1'b1;
            chk("done_words", 32'(got), 32'(n));
            chk("done_time", 32'(cyc), (n > 0) ? 32'(last + 1) : 32'd0);
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("valid_at_done", 32'(out_valid), 32'd0);
         end else if (n > 0) begin
            chk("busy_drain", 32'(busy), 32'd1);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("extra_word", 32'(got + 1), 32'(n));
            else               chk("data", 32'(out_data), 32'(q.pop_front()));
            got++;
            last = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         tick();
         cyc++;
         if (abort >= 0 && got == abort) aborted = 1'b1;
      end
      out_ready = 1'b0;
      if (!aborted) begin
         chk("done_seen", 32'(seen_done), 32'd1);
         chk("done_one_cycle", 32'(done), 32'd0);
         chk("level_after", 32'(level), 32'd0);
         chk("in_ready_after", 32'(in_ready), 32'd1);
         chk("busy_after", 32'(busy), 32'd0);
      end
      $display("drain: mode=%0d words=%0d delivered=%0d cycles=%0d aborted=%0d", mode, n, got, cyc, aborted);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_data"}, 32'(out_data), 32'd0);
      chk({tag, "_ram_w_r"}, 32'(ram_w_r), 32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_ram_din"}, 32'(ram_din), 32'd0);
      chk({tag, "_level"}, 32'(level), 32'd0);
   endtask

   initial begin
      // Power-on reset
      rst_n = 1'b0;
      tick();
      check_reset_outputs("rst");
      tick();
      rst_n = 1'b1;
      tick();
      chk("in_ready_post_rst", 32'(in_ready), 32'd1);
      $display("reset: released");

      // Empty drain: done next cycle, no busy, no data
      drain(0, -1, 1'b0);

      // Three-word frame, sink always ready
      fill_word(8'h11);
      fill_word(8'h22);
      fill_word(8'h33);
      drain(0, -1, 1'b0);

      // Four words with a stalling sink
      for (int i = 0; i < 4; i++) fill_word(8'($urandom));
      drain(1, -1, 1'b0);

      // Full buffer; the extra offer must be refused
      for (int i = 0; i < DEPTH; i++) fill_word(i[7:0]);
      chk("level_full", 32'(level), 32'(DEPTH));
      fill_word(8'hAA);
      chk("level_still_full", 32'(level), 32'(DEPTH));
      drain(0, -1, 1'b0);

      // start wins over a simultaneous fill offer
      fill_word(8'h5A);
      fill_word(8'hA5);
      drain(0, -1, 1'b1);

      // Randomized frames with fill gaps and random backpressure
      for (int r = 0; r < 6; r++) begin
         int n;
         n = $urandom_range(0, 40);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            fill_word(8'($urandom));
         end
         drain(2, -1, 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a drain discards the rest of the frame
      for (int i = 0; i < 5; i++) fill_word(8'($urandom));
      drain(0, 2, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      q.delete();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_done_after_rst", 32'(done), 32'd0);
         chk("idle_after_rst", 32'(busy), 32'd0);
      end
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);
      $display("reset: mid-drain abort");

      // Fresh frame after the abort
      for (int i = 0; i < 7; i++) fill_word(8'($urandom));
      drain(2, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/sci_frame_buf.md
SCI_FRAME_BUF -- requirements
Module: sci_frame_buf

Interface
REQ-001 Parameter WIDTH, default 8, RAM word and stream data width in bits.
REQ-002 Parameter DEPTH, default 512, RAM word count; A = ceil(log2(DEPTH)) SHALL be derived, not overridden.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  fill-side word offered.
REQ-006 in_ready  out  1  fill-side word accepted when in_valid && in_ready.
REQ-007 in_data  in  WIDTH  fill-side word.
REQ-008 start  in  1  single-cycle drain request.
REQ-009 busy  out  1  high while draining.
REQ-010 done  out  1  one-cycle pulse, drain complete.
REQ-011 level  out  A+1  words currently stored, 0..DEPTH.
REQ-012 out_valid  out  1  drain-side word available.
REQ-013 out_ready  in  1  drain-side sink accepts; transfer on out_valid && out_ready.
REQ-014 out_data  out  WIDTH  drain-side word.
REQ-015 ram_addr  out  A  RAM address.
REQ-016 ram_w_r  out  1  1 = write, 0 = read.
REQ-017 ram_din  out  WIDTH  RAM write data.
REQ-018 ram_dout  in  WIDTH  RAM read data, valid exactly one clk after a read address is presented.

Function
REQ-019 States: IDLE, DRAIN, FIN; IDLE -> DRAIN on start with level>0; IDLE -> FIN on start with level=0; DRAIN -> FIN when last word transferred; FIN -> IDLE after one cycle.
REQ-020 in_ready = (state==IDLE) && (level<DEPTH) && !start, combinational.
REQ-021 On accepted fill word: ram_w_r=1, ram_addr=level[A-1:0], ram_din=in_data in the same cycle; level increments by 1 next edge.
REQ-022 level==DEPTH: in_ready=0, no RAM write, level unchanged.
REQ-023 start outside IDLE SHALL be ignored; start in IDLE takes priority over a simultaneous in_valid (word not accepted).
REQ-024 DRAIN reads addresses 0..level-1 in ascending order; ram_w_r=0 whenever no fill write occurs.
REQ-025 Read data SHALL enter a 2-entry output skid buffer; a read is issued only when (buffered + in-flight) < 2 and words remain.
REQ-026 out_valid/out_data driven from skid head; out_data stable while out_valid && !out_ready.
REQ-027 With out_ready held high, first out_valid 2 cycles after start, then one word per cycle, no gaps.
REQ-028 Backpressure of any length SHALL lose, duplicate or reorder no word.
REQ-029 busy = (state==DRAIN), registered.
REQ-030 done pulses for exactly one cycle in FIN; level cleared to 0 on entering FIN.
REQ-031 Drain of level==DEPTH SHALL wrap read address correctly at DEPTH-1 and emit DEPTH words.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, level=0, read pointer=0, skid buffer empty, in-flight flag clear.
REQ-033 Outputs during/after reset: in_ready=1 (after release), busy=0, done=0, out_valid=0, out_data=0, ram_w_r=0, ram_addr=0, ram_din=0.
REQ-034 Reset mid-drain SHALL discard all undelivered words; no done pulse.

Structure
REQ-035 Package sci_buf_pkg SHALL hold the state enumeration and WIDTH/DEPTH defaults.
REQ-036 Skid buffer SHALL be sub-module sci_skid2 (2-entry, valid/ready both sides); RAM is external.

Verification
REQ-037 Fill 0x11,0x22,0x33, start, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, first 2 cycles after start, done 1 cycle after last, level=0.
REQ-038 Fill 4 words, start, out_ready toggling 1,0,0,1,0,1... -> same 4 words in order, out_data held during stalls.
REQ-039 level=0, start -> done pulse next cycle, busy never high, out_valid never high.
REQ-040 Fill 512 words (value=addr[7:0]) -> in_ready=0, 513th offer not written; drain yields 512 words 0x00..0xFF twice.
REQ-041 start and in_valid same cycle in IDLE with level=2 -> word not written, exactly 2 words drained.
REQ-042 Assert rst_n=0 after 2 of 5 words drained -> out_valid=0 immediately, level=0, no done; fresh fill/drain works.
